interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
// - M-mode interrupt source feeding E_IRQ/T_IRQ/S_IRQ to machine control: 64-bit machine timer
//   with compare, software-interrupt bit, NUM_EXT synchronized external lines with pending/enable.
// - Memory-mapped slave on the data bus; MTIME also exported to the CSR file (time/timeh).
// PARAMETERS
// - NUM_EXT   8   external interrupt lines, 1..32
// - PRESCALE  1   mtime tick period in CLK cycles, >=1 (used only with INTC_PRESCALER_EN)
// PORTS
// - CLK        in   1        clock
// - RESET      in   1        synchronous, active-high reset
// - IRQ_IN     in   NUM_EXT  asynchronous external interrupt lines
// - BUS_ADDR   in   5        byte address, bits [1:0] ignored
// - BUS_WE     in   1        write strobe, one word per cycle
// - BUS_RE     in   1        read strobe
// - BUS_WDATA  in   32       write data
// - BUS_RDATA  out  32       read data, valid cycle after BUS_RE
// - E_IRQ      out  1        external interrupt request
// - T_IRQ      out  1        timer interrupt request
// - S_IRQ      out  1        software interrupt request
// - MTIME      out  64       current mtime
// BEHAVIOUR
// - Register map: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//   0x10 MSIP (bit0), 0x14 EXT_PENDING (W1C, edge bits only), 0x18 EXT_ENABLE, 0x1C EXT_MODE (1=edge).
//   Bits >= NUM_EXT read 0; unmapped/undriven bits read 0; writes to them ignored.
// - Reset values: mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF, MSIP 0, pending/enable/mode 0,
//   sync flops 0, E_IRQ/T_IRQ/S_IRQ 0, BUS_RDATA 0.
// - mtime: +1 per tick, wraps 2^64-1 -> 0. Bus write to MTIME_LO/HI replaces that half; write wins
//   over increment that cycle (no tick applied). Same for MTIMECMP halves (no increment there).
// - T_IRQ registered: T_IRQ <= (mtime >= mtimecmp), unsigned 64-bit, 1-cycle latency; level,
//   deasserted only by raising mtimecmp or writing mtime.
// - S_IRQ registered from MSIP bit0: visible cycle after write.
// - IRQ_IN: 2-flop sync (s1,s2) plus s3 for edge detect. Level bit: pending = s2 (read-only).
//   Edge bit: pending set on s2 & ~s3; cleared by W1C; set wins over simultaneous clear.
// - E_IRQ <= |(pending & enable), registered. IRQ_IN sampled high at edge k -> E_IRQ high after k+3.
// - Mode change edge->level discards latched edge pending; level->edge starts with pending 0.
// - Read: BUS_RDATA <= selected reg at edge after BUS_RE; holds until next read. WE+RE same cycle:
//   write performed, read returns pre-write value.
// - RESET asserted mid-operation restores all reset values next edge, regardless of bus activity.
// CONFIGURATION
// - INTC_PRESCALER_EN defined: 16-bit tick counter counts 0..PRESCALE-1, mtime increments when
//   counter wraps; counter cleared on reset and on any mtime write.
// - Undefined: mtime increments every CLK cycle; PRESCALE ignored; no tick counter.
// TESTING
// - Reset, read all 8 regs -> 0,0,FFFFFFFF,FFFFFFFF,0,0,0,0; all IRQ outputs 0.
// - Write MTIMECMP={0,20}, MTIME={0,0} -> T_IRQ rises when mtime reads 21 (1 after match); write
//   MTIMECMP_LO=100 -> T_IRQ 0 next cycle.
// - Write MTIME={0,FFFFFFFF}, run 2 ticks -> MTIME_HI=1, MTIME_LO=1 (carry across halves).
// - EXT_MODE=1, EXT_ENABLE=1, pulse IRQ_IN[0] 1 cycle -> pending[0]=1, E_IRQ=1 at k+3; W1C 0x1 ->
//   E_IRQ 0 two cycles later; W1C coinciding with new edge -> pending stays 1.
// - EXT_MODE=0, IRQ_IN[3] held high, enable bit3 -> E_IRQ high; W1C ignored; release line -> E_IRQ 0
//   after 3 cycles.
// - MSIP write 1 then 0 -> S_IRQ 1 then 0, each 1 cycle after write; RESET mid-count -> mtime 0.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller: M-mode machine timer, software and external interrupt source on a memory-mapped bus.
// Ports: CLK/RESET (sync, active-high); IRQ_IN async external lines; BUS_* word-wide slave
// (BUS_RDATA valid the cycle after BUS_RE); E_IRQ/T_IRQ/S_IRQ registered requests; MTIME live timer.
// Map: 00 MTIME_LO, 04 MTIME_HI, 08 MTIMECMP_LO, 0C MTIMECMP_HI, 10 MSIP, 14 EXT_PENDING (W1C),
// 18 EXT_ENABLE, 1C EXT_MODE (1=edge). Define INTC_PRESCALER_EN to tick mtime every PRESCALE cycles.
module interrupt_controller #(
  parameter int NUM_EXT  = 8,
  parameter int PRESCALE = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_EXT-1:0] IRQ_IN,
  input  logic [4:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic               BUS_RE,
  input  logic [31:0]        BUS_WDATA,
  output logic [31:0]        BUS_RDATA,
  output logic               E_IRQ,
  output logic               T_IRQ,
  output logic               S_IRQ,
  output logic [63:0]        MTIME
);
  logic [63:0] mtime, mtimecmp, mtime_nxt;
  logic msip, tick, unused_addr;
  logic wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_msip, wr_pend, wr_en, wr_mode;
  logic [NUM_EXT-1:0] s1, s2, s3, pend, en, mode, mode_nxt, clr, rise, pend_nxt;
  logic [31:0] rd_val;
  assign unused_addr = ^BUS_ADDR[1:0];
  assign wr_lo     = BUS_WE && BUS_ADDR[4:2] == 3'd0;
  assign wr_hi     = BUS_WE && BUS_ADDR[4:2] == 3'd1;
  assign wr_cmp_lo = BUS_WE && BUS_ADDR[4:2] == 3'd2;
  assign wr_cmp_hi = BUS_WE && BUS_ADDR[4:2] == 3'd3;
  assign wr_msip   = BUS_WE && BUS_ADDR[4:2] == 3'd4;
  assign wr_pend   = BUS_WE && BUS_ADDR[4:2] == 3'd5;
  assign wr_en     = BUS_WE && BUS_ADDR[4:2] == 3'd6;
  assign wr_mode   = BUS_WE && BUS_ADDR[4:2] == 3'd7;
`ifdef INTC_PRESCALER_EN
  logic [15:0] cnt;
  assign tick = cnt == 16'(PRESCALE - 1);
  always_ff @(posedge CLK)
    cnt <= (RESET || wr_lo || wr_hi || tick) ? 16'd0 : cnt + 16'd1;
`else
  assign tick = 1'b1;
`endif
  // A bus write to either half replaces it and suppresses that cycle's tick.
  assign mtime_nxt = wr_lo ? {mtime[63:32], BUS_WDATA} :
                     wr_hi ? {BUS_WDATA, mtime[31:0]} : mtime + {63'd0, tick};
  // Pending follows the mode in force after this edge: level bits track s2, edge bits latch
  // rising edges. Masking the held value with the current mode makes a level->edge switch start
  // clear; a new edge beats a simultaneous W1C.
  assign mode_nxt = wr_mode ? BUS_WDATA[NUM_EXT-1:0] : mode;
  assign clr      = wr_pend ? BUS_WDATA[NUM_EXT-1:0] : '0;
  assign rise     = s2 & ~s3;
  assign pend_nxt = (mode_nxt & ((pend & mode & ~clr) | rise)) | (~mode_nxt & s2);
  always_comb begin
    rd_val = '0;
    case (BUS_ADDR[4:2])
      3'd0: rd_val = mtime[31:0];
      3'd1: rd_val = mtime[63:32];
      3'd2: rd_val = mtimecmp[31:0];
      3'd3: rd_val = mtimecmp[63:32];
      3'd4: rd_val = {31'd0, msip};
      3'd5: rd_val = 32'(pend);
      3'd6: rd_val = 32'(en);
      default: rd_val = 32'(mode);
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      {s1, s2, s3, pend, en, mode} <= '0;
      {E_IRQ, T_IRQ, S_IRQ} <= 3'b000;
      BUS_RDATA <= '0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= wr_cmp_lo ? {mtimecmp[63:32], BUS_WDATA} :
                  wr_cmp_hi ? {BUS_WDATA, mtimecmp[31:0]} : mtimecmp;
      msip     <= wr_msip ? BUS_WDATA[0] : msip;
      s1       <= IRQ_IN;
      s2       <= s1;
      s3       <= s2;
      pend     <= pend_nxt;
      en       <= wr_en ? BUS_WDATA[NUM_EXT-1:0] : en;
      mode     <= mode_nxt;
      E_IRQ    <= |(pend & en);
      T_IRQ    <= mtime >= mtimecmp;
      S_IRQ    <= msip;
      if (BUS_RE) BUS_RDATA <= rd_val;
    end
  end
  assign MTIME = mtime;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed table and sequence checks for interrupt_controller.
module tb_interrupt_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  IRQ_IN = '0;
  logic [4:0]  BUS_ADDR = '0;
  logic        BUS_WE = 1'b0;
  logic        BUS_RE = 1'b0;
  logic [31:0] BUS_WDATA = '0;
  logic [31:0] BUS_RDATA;
  logic        E_IRQ, T_IRQ, S_IRQ;
  logic [63:0] MTIME;
  int n_cmp = 0;
  int n_err = 0;

  interrupt_controller #(.NUM_EXT(8), .PRESCALE(1)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
    .BUS_RE(BUS_RE), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .E_IRQ(E_IRQ),
    .T_IRQ(T_IRQ), .S_IRQ(S_IRQ), .MTIME(MTIME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    BUS_ADDR = a; BUS_WDATA = d; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
    BUS_ADDR = a; BUS_RE = 1'b1;
    @(negedge CLK);
    BUS_RE = 1'b0;
    chk(nm, 64'(BUS_RDATA), 64'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rst_exp [8];
    vec_t tv [9];
    int i;
    rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    tv = '{
      '{5'h18, 32'hFFFF_FFFF, 32'h0000_00FF},
      '{5'h1C, 32'h1234_56A5, 32'h0000_00A5},
      '{5'h10, 32'hFFFF_FFFF, 32'h0000_0001},
      '{5'h08, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
      '{5'h0C, 32'h0BAD_F00D, 32'h0BAD_F00D},
      '{5'h14, 32'hFFFF_FFFF, 32'h0000_0000},
      '{5'h18, 32'h0000_0000, 32'h0000_0000},
      '{5'h10, 32'h0000_0000, 32'h0000_0000},
      '{5'h1C, 32'h0000_0000, 32'h0000_0000}
    };
    step(2);
    chk("rst_rdata", 64'(BUS_RDATA), 64'h0);
    chk("rst_irqs", 64'({E_IRQ, T_IRQ, S_IRQ}), 64'h0);
    chk("rst_mtime", MTIME, 64'h0);
    RESET = 1'b0;
    // First read captures mtime before its first tick, so MTIME_LO reads 0.
    for (int k = 0; k < 8; k++) rd(5'(k * 4), rst_exp[k], $sformatf("rst_reg%0h", k * 4));
    chk("rst_irqs_run", 64'({E_IRQ, T_IRQ, S_IRQ}), 64'h0);
    for (int k = 0; k < 9; k++) begin
      wr(tv[k].addr, tv[k].wdata);
      rd(tv[k].addr, tv[k].exp, $sformatf("vec%0d", k));
    end
    // Write and read together: read returns pre-write value.
    BUS_ADDR = 5'h10; BUS_WDATA = 32'h1; BUS_WE = 1'b1; BUS_RE = 1'b1;
    step(1);
    BUS_WE = 1'b0; BUS_RE = 1'b0;
    chk("we_re_old", 64'(BUS_RDATA), 64'h0);
    rd(5'h10, 32'h1, "we_re_new");
    wr(5'h10, 32'h0);
    // Timer compare: T_IRQ rises when mtime reads 21.
    wr(5'h08, 32'd20);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'h0);
    wr(5'h0C, 32'h0);
    for (i = 0; i < 100; i++) begin
      if (T_IRQ) break;
      step(1);
    end
    chk("t_irq_rise", 64'(T_IRQ), 64'h1);
    chk("mtime_at_tirq", MTIME, 64'd21);
    wr(5'h08, 32'd100);
    chk("t_irq_hold", 64'(T_IRQ), 64'h1);
    step(1);
    chk("t_irq_fall", 64'(T_IRQ), 64'h0);
    // Carry across halves and full wrap.
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF);
    chk("mtime_wr_no_tick", MTIME, 64'h0000_0000_FFFF_FFFF);
    step(1);
    chk("mtime_carry", MTIME, 64'h0000_0001_0000_0000);
    step(1);
    chk("mtime_carry2", MTIME, 64'h0000_0001_0000_0001);
    rd(5'h04, 32'h1, "mtime_hi_rd");
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFF);
    chk("mtime_max", MTIME, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    chk("mtime_wrap", MTIME, 64'h0);
    wr(5'h00, 32'd5);
    chk("mtime_lo_wr", MTIME, 64'd5);
    // Edge-mode external interrupt.
    wr(5'h1C, 32'h1);
    wr(5'h18, 32'h1);
    IRQ_IN = 8'h01;
    step(1);
    IRQ_IN = 8'h00;
    step(2);
    chk("edge_e_k2", 64'(E_IRQ), 64'h0);
    step(1);
    chk("edge_e_k3", 64'(E_IRQ), 64'h1);
    rd(5'h14, 32'h1, "edge_pend");
    wr(5'h14, 32'h1);
    chk("w1c_e_hold", 64'(E_IRQ), 64'h1);
    step(1);
    chk("w1c_e_fall", 64'(E_IRQ), 64'h0);
    rd(5'h14, 32'h0, "w1c_pend");
    IRQ_IN = 8'h01;
    step(1);
    IRQ_IN = 8'h00;
    step(1);
    wr(5'h14, 32'h1);
    rd(5'h14, 32'h1, "set_beats_clr");
    wr(5'h1C, 32'h0);
    rd(5'h14, 32'h0, "edge2level_discard");
    // Level-mode external interrupt on line 3.
    wr(5'h18, 32'h8);
    IRQ_IN = 8'h08;
    step(3);
    chk("lvl_e_k2", 64'(E_IRQ), 64'h0);
    step(1);
    chk("lvl_e_k3", 64'(E_IRQ), 64'h1);
    rd(5'h14, 32'h8, "lvl_pend");
    wr(5'h14, 32'h8);
    rd(5'h14, 32'h8, "lvl_w1c_ignored");
    chk("lvl_e_hold", 64'(E_IRQ), 64'h1);
    IRQ_IN = 8'h00;
    step(3);
    chk("lvl_rel_k2", 64'(E_IRQ), 64'h1);
    step(1);
    chk("lvl_rel_k3", 64'(E_IRQ), 64'h0);
    // Software interrupt.
    wr(5'h10, 32'h1);
    chk("msip_s_0", 64'(S_IRQ), 64'h0);
    step(1);
    chk("msip_s_1", 64'(S_IRQ), 64'h1);
    wr(5'h10, 32'h0);
    chk("msip_s_hold", 64'(S_IRQ), 64'h1);
    step(1);
    chk("msip_s_clr", 64'(S_IRQ), 64'h0);
    // Reset mid-count with a write pending on the bus.
    wr(5'h08, 32'h0);
    wr(5'h0C, 32'h0);
    wr(5'h10, 32'h1);
    rd(5'h08, 32'h0, "cmp_zero");
    step(5);
    BUS_ADDR = 5'h00; BUS_WDATA = 32'h55; BUS_WE = 1'b1; RESET = 1'b1;
    step(1);
    BUS_WE = 1'b0;
    chk("rst_mid_mtime", MTIME, 64'h0);
    chk("rst_mid_rdata", 64'(BUS_RDATA), 64'h0);
    chk("rst_mid_irqs", 64'({E_IRQ, T_IRQ, S_IRQ}), 64'h0);
    RESET = 1'b0;
    rd(5'h08, 32'hFFFF_FFFF, "rst_mid_cmp");
    rd(5'h10, 32'h0, "rst_mid_msip");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
